mips_multicycle_control: RTL and testbench

Multi-cycle main control FSM for the MIPS core. Sequences the shared ALU, memory port, instruction register, register file and PC through fetch, decode, execute, memory and writeback steps. Drives the 2-bit ALUop consumed by the ALU control unit (00 add, 01 sub/beq, 10 R-format funct, 11 and). Also counts retired instructions.

---
 rtl/mips_multicycle_control_if.sv | 41 ++++
 rtl/mips_multicycle_control.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control-unit bus for the multi-cycle MIPS core: IR fields and memory handshake in,
// datapath strobes, ALU op, state and retirement status out.
interface mips_multicycle_control_if;
  logic [5:0]  Opcode;
  logic [5:0]  Function;
  logic        Zero;
  logic        MemReady;

  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        RegDst;
  logic        ALUSrcA;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUop;
  logic [3:0]  State;
  logic        InstrDone;
  logic        IllegalOp;
  logic [15:0] InstrCount;

  // The control unit is the master: it reads the IR/handshake and drives the datapath.
  modport master (
    input  Opcode, Function, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop, State,
           InstrDone, IllegalOp, InstrCount
  );

  modport slave (
    output Opcode, Function, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop, State,
           InstrDone, IllegalOp, InstrCount
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter.
// Define MIPS_MEM_WAIT_EN to let MemReady stall the fetch and memory states.
module mips_multicycle_control (
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11,
    S_JR        = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  state_t      state;
  state_t      next_state;
  ctrl_t       ctrl;
  ctrl_t       ctrl_out;
  logic [15:0] instr_count;
  logic        mem_ready;

`ifdef MIPS_MEM_WAIT_EN
  assign mem_ready = bus.MemReady;
  logic unused_inputs;
  assign unused_inputs = bus.Zero;
`else
  // Zero-wait memory: every memory access completes in the cycle it is issued.
  assign mem_ready = 1'b1;
  logic unused_inputs;
  assign unused_inputs = bus.Zero ^ bus.MemReady;
`endif

  logic is_rtype, is_jr, is_lw, is_sw, is_addi, is_andi, is_beq, is_j;

  assign is_rtype = (bus.Opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (bus.Function == FN_JR);
  assign is_lw    = (bus.Opcode == OP_LW);
  assign is_sw    = (bus.Opcode == OP_SW);
  assign is_addi  = (bus.Opcode == OP_ADDI);
  assign is_andi  = (bus.Opcode == OP_ANDI);
  assign is_beq   = (bus.Opcode == OP_BEQ);
  assign is_j     = (bus.Opcode == OP_J);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    next_state = state;
    ctrl       = '0;

    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.pc_write = 1'b1;
          ctrl.ir_write = 1'b1;
          next_state    = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
        if (is_rtype)              next_state = is_jr ? S_JR : S_EXEC_R;
        else if (is_lw || is_sw)   next_state = S_MEM_ADDR;
        else if (is_addi || is_andi) next_state = S_EXEC_I;
        else if (is_beq)           next_state = S_BRANCH;
        else if (is_j)             next_state = S_JUMP;
        else begin
          ctrl.illegal_op = 1'b1;
          next_state      = S_FETCH;
        end
      end

      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (is_lw)      next_state = S_MEM_READ;
        else if (is_sw) next_state = S_MEM_WRITE;
        else            next_state = S_FETCH;
      end

      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end

      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        if (mem_ready) begin
          ctrl.instr_done = 1'b1;
          next_state      = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNC;
        next_state     = S_R_WB;
      end

      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end

      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = is_andi ? ALU_AND : ALU_ADD;
        next_state     = S_I_WB;
      end

      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        next_state         = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end

      S_JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_RS;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end

      // Unused encodings recover to FETCH with everything deasserted.
      default: next_state = S_FETCH;
    endcase
  end

  // NOTE: state and counter use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (ctrl.instr_done) instr_count <= instr_count + 16'd1;
    end
  end

  // Reset kills every strobe combinationally, so a write in flight is dropped the instant rst_n falls.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.PCWrite     = ctrl_out.pc_write;
  assign bus.PCWriteCond = ctrl_out.pc_write_cond;
  assign bus.IorD        = ctrl_out.ior_d;
  assign bus.MemRead     = ctrl_out.mem_read;
  assign bus.MemWrite    = ctrl_out.mem_write;
  assign bus.IRWrite     = ctrl_out.ir_write;
  assign bus.MemtoReg    = ctrl_out.mem_to_reg;
  assign bus.RegWrite    = ctrl_out.reg_write;
  assign bus.RegDst      = ctrl_out.reg_dst;
  assign bus.ALUSrcA     = ctrl_out.alu_src_a;
  assign bus.PCSource    = ctrl_out.pc_source;
  assign bus.ALUSrcB     = ctrl_out.alu_src_b;
  assign bus.ALUop       = ctrl_out.alu_op;
  assign bus.InstrDone   = ctrl_out.instr_done;
  assign bus.IllegalOp   = ctrl_out.illegal_op;
  assign bus.State       = state;
  assign bus.InstrCount  = instr_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed scoreboard bench for mips_multicycle_control; expected per-cycle
// state/controls/count are queued per instruction, then popped and compared each cycle.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();
  mips_multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Control vector layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
  // RegWrite RegDst ALUSrcA PCSource[2] ALUSrcB[2] ALUop[2] InstrDone IllegalOp
  localparam logic [17:0] PCW   = 18'h20000, PCWC = 18'h10000, IORD = 18'h08000;
  localparam logic [17:0] MRD   = 18'h04000, MWR  = 18'h02000, IRW  = 18'h01000;
  localparam logic [17:0] M2R   = 18'h00800, RGW  = 18'h00400, RDST = 18'h00200;
  localparam logic [17:0] SRCA  = 18'h00100;
  localparam logic [17:0] PCS_ALUOUT = 18'h00040, PCS_JMP = 18'h00080, PCS_RS = 18'h000C0;
  localparam logic [17:0] SRCB_4 = 18'h00010, SRCB_IMM = 18'h00020, SRCB_SH = 18'h00030;
  localparam logic [17:0] OP_SUB = 18'h00004, OP_R = 18'h00008, OP_AND = 18'h0000C;
  localparam logic [17:0] DONE  = 18'h00002, ILL = 18'h00001;

  localparam logic [17:0] C_FETCH   = MRD | SRCB_4 | PCW | IRW;
  localparam logic [17:0] C_FETCH_W = MRD | SRCB_4;
  localparam logic [17:0] C_DEC     = SRCB_SH;
  localparam logic [17:0] C_DEC_ILL = SRCB_SH | ILL;
  localparam logic [17:0] C_MADDR   = SRCA | SRCB_IMM;
  localparam logic [17:0] C_MREAD   = MRD | IORD;
  localparam logic [17:0] C_MWB     = RGW | M2R | DONE;
  localparam logic [17:0] C_MWR     = MWR | IORD | DONE;
  localparam logic [17:0] C_MWR_W   = MWR | IORD;
  localparam logic [17:0] C_EXR     = SRCA | OP_R;
  localparam logic [17:0] C_RWB     = RGW | RDST | DONE;
  localparam logic [17:0] C_ADDI    = SRCA | SRCB_IMM;
  localparam logic [17:0] C_ANDI    = SRCA | SRCB_IMM | OP_AND;
  localparam logic [17:0] C_IWB     = RGW | DONE;
  localparam logic [17:0] C_BR      = SRCA | OP_SUB | PCWC | PCS_ALUOUT | DONE;
  localparam logic [17:0] C_J       = PCW | PCS_JMP | DONE;
  localparam logic [17:0] C_JR      = PCW | PCS_RS | DONE;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3;
  localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_R_WB = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_EXEC_I = 4'd10, S_I_WB = 4'd11;
  localparam logic [3:0] S_JR = 4'd12;

  typedef struct {
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_cnt;

  function automatic logic [17:0] observed_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA, bus.PCSource, bus.ALUSrcB,
            bus.ALUop, bus.InstrDone, bus.IllegalOp};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Queue one expected cycle; the retirement count advances after any cycle flagged DONE.
  task automatic push(input logic mr, input logic [3:0] st, input logic [17:0] c, input string tag);
    exp_t e;
    e.mr = mr; e.st = st; e.ctrl = c; e.cnt = exp_cnt; e.tag = tag;
    sb.push_back(e);
    if ((c & DONE) != 18'h0) exp_cnt = exp_cnt + 16'd1;
  endtask

  // Entered just after a falling edge; each step drives MemReady, compares, then waits a cycle.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.MemReady = e.mr;
      #1;
      check({e.tag, ".state"}, {28'h0, bus.State}, {28'h0, e.st});
      check({e.tag, ".ctrl"},  {14'h0, observed_ctrl()}, {14'h0, e.ctrl});
      check({e.tag, ".count"}, {16'h0, bus.InstrCount}, {16'h0, e.cnt});
      @(negedge clk);
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    bus.Opcode   = op;
    bus.Function = fn;
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;
    set_instr(6'd0, 6'd0);
    exp_cnt      = 16'd0;

    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("reset.state", {28'h0, bus.State}, 32'd0);
    check("reset.ctrl",  {14'h0, observed_ctrl()}, 32'd0);
    check("reset.count", {16'h0, bus.InstrCount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add
    set_instr(6'd0, 6'd32);
    push(1, S_FETCH, C_FETCH, "add.fetch"); push(1, S_DECODE, C_DEC, "add.decode");
    push(1, S_EXEC_R, C_EXR, "add.exec");   push(1, S_R_WB, C_RWB, "add.wb");
    drain();

    // lw, zero wait
    set_instr(6'd35, 6'd0);
    push(1, S_FETCH, C_FETCH, "lw.fetch");  push(1, S_DECODE, C_DEC, "lw.decode");
    push(1, S_MEM_ADDR, C_MADDR, "lw.addr"); push(1, S_MEM_READ, C_MREAD, "lw.read");
    push(1, S_MEM_WB, C_MWB, "lw.wb");
    drain();

`ifdef MIPS_MEM_WAIT_EN
    // lw with one fetch stall and two read stalls
    set_instr(6'd35, 6'd0);
    push(0, S_FETCH, C_FETCH_W, "lww.fetch_wait"); push(1, S_FETCH, C_FETCH, "lww.fetch");
    push(1, S_DECODE, C_DEC, "lww.decode");        push(1, S_MEM_ADDR, C_MADDR, "lww.addr");
    push(0, S_MEM_READ, C_MREAD, "lww.read_w0");   push(0, S_MEM_READ, C_MREAD, "lww.read_w1");
    push(1, S_MEM_READ, C_MREAD, "lww.read");      push(1, S_MEM_WB, C_MWB, "lww.wb");
    drain();
    // sw with one write stall
    set_instr(6'd43, 6'd0);
    push(1, S_FETCH, C_FETCH, "sww.fetch");         push(1, S_DECODE, C_DEC, "sww.decode");
    push(1, S_MEM_ADDR, C_MADDR, "sww.addr");       push(0, S_MEM_WRITE, C_MWR_W, "sww.write_w");
    push(1, S_MEM_WRITE, C_MWR, "sww.write");
    drain();
`else
    // MemReady low must be ignored: fetch and store still complete in one cycle each
    set_instr(6'd43, 6'd0);
    push(0, S_FETCH, C_FETCH, "swi.fetch");   push(0, S_DECODE, C_DEC, "swi.decode");
    push(0, S_MEM_ADDR, C_MADDR, "swi.addr"); push(0, S_MEM_WRITE, C_MWR, "swi.write");
    drain();
`endif

    // sw, zero wait
    set_instr(6'd43, 6'd0);
    push(1, S_FETCH, C_FETCH, "sw.fetch");   push(1, S_DECODE, C_DEC, "sw.decode");
    push(1, S_MEM_ADDR, C_MADDR, "sw.addr"); push(1, S_MEM_WRITE, C_MWR, "sw.write");
    drain();

    // beq then andi then addi
    set_instr(6'd4, 6'd0);
    push(1, S_FETCH, C_FETCH, "beq.fetch"); push(1, S_DECODE, C_DEC, "beq.decode");
    push(1, S_BRANCH, C_BR, "beq.branch");
    drain();
    set_instr(6'd12, 6'd0);
    push(1, S_FETCH, C_FETCH, "andi.fetch"); push(1, S_DECODE, C_DEC, "andi.decode");
    push(1, S_EXEC_I, C_ANDI, "andi.exec");  push(1, S_I_WB, C_IWB, "andi.wb");
    drain();
    set_instr(6'd8, 6'd0);
    push(1, S_FETCH, C_FETCH, "addi.fetch"); push(1, S_DECODE, C_DEC, "addi.decode");
    push(1, S_EXEC_I, C_ADDI, "addi.exec");  push(1, S_I_WB, C_IWB, "addi.wb");
    drain();

    // j and jr
    set_instr(6'd2, 6'd0);
    push(1, S_FETCH, C_FETCH, "j.fetch"); push(1, S_DECODE, C_DEC, "j.decode");
    push(1, S_JUMP, C_J, "j.jump");
    drain();
    set_instr(6'd0, 6'd8);
    push(1, S_FETCH, C_FETCH, "jr.fetch"); push(1, S_DECODE, C_DEC, "jr.decode");
    push(1, S_JR, C_JR, "jr.jr");
    drain();

    // illegal opcode: pulse, straight back to FETCH, no retirement
    set_instr(6'd63, 6'd0);
    push(1, S_FETCH, C_FETCH, "ill.fetch"); push(1, S_DECODE, C_DEC_ILL, "ill.decode");
    drain();
    set_instr(6'd0, 6'd32);
    push(1, S_FETCH, C_FETCH, "post_ill.fetch"); push(1, S_DECODE, C_DEC, "post_ill.decode");
    push(1, S_EXEC_R, C_EXR, "post_ill.exec");   push(1, S_R_WB, C_RWB, "post_ill.wb");
    drain();

    // counter wrap: preload near the top instead of retiring 65534 jumps
    force dut.instr_count = 16'hFFFE;
    #1;
    release dut.instr_count;
    exp_cnt = 16'hFFFE;
    set_instr(6'd2, 6'd0);
    push(1, S_FETCH, C_FETCH, "wrap1.fetch"); push(1, S_DECODE, C_DEC, "wrap1.decode");
    push(1, S_JUMP, C_J, "wrap1.jump");
    push(1, S_FETCH, C_FETCH, "wrap2.fetch"); push(1, S_DECODE, C_DEC, "wrap2.decode");
    push(1, S_JUMP, C_J, "wrap2.jump");
    push(1, S_FETCH, C_FETCH, "wrap.after");
    drain();
    // wrap.after left the DUT in DECODE of a j; finish that jump
    push(1, S_DECODE, C_DEC, "wrap3.decode"); push(1, S_JUMP, C_J, "wrap3.jump");
    drain();

    // reset during MEM_WRITE with MemReady high
    set_instr(6'd43, 6'd0);
    push(1, S_FETCH, C_FETCH, "rsw.fetch"); push(1, S_DECODE, C_DEC, "rsw.decode");
    push(1, S_MEM_ADDR, C_MADDR, "rsw.addr");
    drain();
    bus.MemReady = 1'b1;
    #1;
    check("rsw.pre.state", {28'h0, bus.State}, {28'h0, S_MEM_WRITE});
    check("rsw.pre.memwrite", {31'h0, bus.MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsw.rst.memwrite", {31'h0, bus.MemWrite}, 32'd0);
    check("rsw.rst.ctrl", {14'h0, observed_ctrl()}, 32'd0);
    check("rsw.rst.state", {28'h0, bus.State}, 32'd0);
    check("rsw.rst.count", {16'h0, bus.InstrCount}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;

    set_instr(6'd0, 6'd32);
    push(1, S_FETCH, C_FETCH, "rec.fetch"); push(1, S_DECODE, C_DEC, "rec.decode");
    push(1, S_EXEC_R, C_EXR, "rec.exec");   push(1, S_R_WB, C_RWB, "rec.wb");
    push(1, S_FETCH, C_FETCH, "rec.after");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
